load_store_unit: RTL and testbench

- Initiator side of the data-memory interface. Accepts byte/half/word load and store requests from the pipeline MEM stage and drives the word-addressed data memory port: address, write_data, mem_read and mem_write, with read_data returned combinationally.
- Converts byte addresses to word indices and performs read-modify-write for sub-word stores.
- Extracts and extends sub-word load data.
- Detects misaligned and out-of-range accesses.

---
 rtl/load_store_unit_pkg.sv | 8 +
 rtl/load_store_unit_if.sv | 29 ++
 rtl/load_store_unit_lane_align.sv | 30 +++
 rtl/load_store_unit.sv | 95 +++++++++
 tb/tb_load_store_unit.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/load_store_unit_pkg.sv
// load_store_unit_pkg: access-size encodings and controller state type shared by the LSU files.
package load_store_unit_pkg;
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {IDLE, RD, RMW_RD, WR, RESP} state_t;
endpackage

// File: rtl/load_store_unit_if.sv
// load_store_unit_if: pipeline request/response channel plus the word-addressed data memory port.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_read_data;

    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready, mem_read_data,
        output req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_data, mem_read, mem_write
    );

    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, resp_ready, mem_read_data,
        input  req_ready, resp_valid, resp_rdata, resp_err, mem_address, mem_write_data, mem_read, mem_write
    );
endinterface

// File: rtl/load_store_unit_lane_align.sv
// lsu_lane_align: little-endian lane extraction/extension for loads and lane merge for sub-word stores.
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_addr,
    input  logic [1:0]  i_size,
    input  logic        i_signed,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_wdata
);
    logic [4:0]  w_bsh;
    logic [4:0]  w_hsh;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_bsh  = {i_addr, 3'b000};
    assign w_hsh  = {i_addr[1], 4'b0000};
    assign w_byte = i_word[w_bsh +: 8];
    assign w_half = i_word[w_hsh +: 16];

    always_comb begin
        o_rdata = i_size == SZ_BYTE ? {{24{i_signed & w_byte[7]}}, w_byte} :
                  i_size == SZ_HALF ? {{16{i_signed & w_half[15]}}, w_half} : i_word;
        o_wdata = i_size == SZ_BYTE ? (i_word & ~(32'h0000_00FF << w_bsh)) | ({24'b0, i_wdata[7:0]} << w_bsh) :
                  i_size == SZ_HALF ? (i_word & ~(32'h0000_FFFF << w_hsh)) | ({16'b0, i_wdata[15:0]} << w_hsh) :
                  i_wdata;
    end
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: single-outstanding byte/half/word load-store initiator for a word-addressed data memory,
// with read-modify-write for sub-word stores and error reporting for bad accesses.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int MEM_WORDS = 256
) (
    input logic              clk,
    input logic              rst,
    load_store_unit_if.slave bus
);
    localparam logic [31:0] LIMIT = 32'(MEM_WORDS * 4);

    state_t      r_state;
    state_t      w_next;
    logic [1:0]  r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_wdata;
    logic        r_resp_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        w_err;
    logic [31:0] w_rdata;
    logic [31:0] w_merged;

    assign w_err = bus.req_size == 2'd3 ||
                   (bus.req_size == SZ_HALF && bus.req_addr[0]) ||
                   (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00) ||
                   bus.req_addr >= LIMIT;

    lsu_lane_align u_align (
        .i_word   (bus.mem_read_data),
        .i_addr   (r_addr),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_wdata  (r_wdata),
        .o_rdata  (w_rdata),
        .o_wdata  (w_merged)
    );

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (bus.req_valid) w_next = w_err ? RESP : !bus.req_write ? RD :
                                                 bus.req_size == SZ_WORD ? WR : RMW_RD;
            RD:      w_next = RESP;
            RMW_RD:  w_next = WR;
            WR:      w_next = RESP;
            RESP:    if (bus.resp_ready) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_addr       <= '0;
            r_size       <= '0;
            r_signed     <= 1'b0;
            r_wdata      <= '0;
            r_resp_valid <= 1'b0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
        end else begin
            r_state      <= w_next;
            r_resp_valid <= w_next == RESP;
            if (r_state == IDLE && bus.req_valid) begin
                r_addr      <= bus.req_addr[1:0];
                r_size      <= bus.req_size;
                r_signed    <= bus.req_signed;
                r_wdata     <= bus.req_wdata;
                r_err       <= w_err;
                r_rdata     <= '0;
                r_mem_addr  <= {2'b00, bus.req_addr[31:2]};
                r_mem_wdata <= bus.req_wdata;
            end
            if (r_state == RD) r_rdata <= w_rdata;
            if (r_state == RMW_RD) r_mem_wdata <= w_merged;
        end
    end

    assign bus.req_ready      = r_state == IDLE;
    assign bus.resp_valid     = r_resp_valid;
    assign bus.resp_rdata     = r_rdata;
    assign bus.resp_err       = r_err;
    assign bus.mem_address    = r_mem_addr;
    assign bus.mem_write_data = r_mem_wdata;
    assign bus.mem_read       = r_state == RD || r_state == RMW_RD;
    assign bus.mem_write      = r_state == WR;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed and random load/store traffic against an array-based memory reference model.
module tb_load_store_unit;
    logic clk;
    logic rst;
    int   total;
    int   bad;

    load_store_unit_if bus ();

    load_store_unit #(.MEM_WORDS(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [31:0] mem     [256];
    logic [31:0] ref_mem [256];

    always @(posedge clk)
        if (bus.mem_write && bus.mem_address < 32'd256) mem[bus.mem_address[7:0]] <= bus.mem_write_data;

    assign bus.mem_read_data = bus.mem_address < 32'd256 ? mem[bus.mem_address[7:0]] : 32'h0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_load(input logic [1:0] sz, input logic sg, input logic [31:0] a);
        logic [31:0] word;
        logic [31:0] v;
        int          sh;
        word = ref_mem[a[9:2]];
        sh   = 8 * int'(a[1:0]);
        if (sz == 2'd0) begin
            v = (word >> sh) & 32'hFF;
            return (sg && v > 32'd127) ? v + 32'hFFFF_FF00 : v;
        end
        if (sz == 2'd1) begin
            v = (word >> sh) & 32'hFFFF;
            return (sg && v > 32'd32767) ? v + 32'hFFFF_0000 : v;
        end
        return word;
    endfunction

    function automatic logic [31:0] exp_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] word;
        logic [31:0] m;
        int          sh;
        word = ref_mem[a[9:2]];
        sh   = 8 * int'(a[1:0]);
        if (sz == 2'd2) return wd;
        m = sz == 2'd0 ? 32'hFF : 32'hFFFF;
        return word - (((word >> sh) & m) << sh) + ((wd & m) << sh);
    endfunction

    task automatic do_op(input logic w, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                         input logic [31:0] wd, input int stall);
        logic        e;
        logic [31:0] er;
        logic [31:0] nwv;
        logic [31:0] wa;
        logic [31:0] wdat;
        int          el;
        int          lat;
        int          nw;
        int          nr;
        e   = sz == 2'd3 || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a % 4 != 0) || a >= 32'd1024;
        el  = e ? 1 : !w ? 2 : sz == 2'd2 ? 2 : 3;
        er  = (e || w) ? 32'h0 : exp_load(sz, sg, a);
        nwv = (w && !e) ? exp_store(sz, a, wd) : 32'h0;
        wa = 0; wdat = 0; nw = 0; nr = 0;
        chk("req_ready_idle", 32'(bus.req_ready), 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        bus.resp_ready = stall == 0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 10) begin
            chk("rd_wr_exclusive", 32'(bus.mem_read & bus.mem_write), 32'd0);
            if (bus.mem_write) begin nw++; wa = bus.mem_address; wdat = bus.mem_write_data; end
            if (bus.mem_read) nr++;
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 32'(lat), 32'(el));
        chk("resp_err", 32'(bus.resp_err), 32'(e));
        chk("resp_rdata", bus.resp_rdata, er);
        chk("write_cycles", 32'(nw), (w && !e) ? 32'd1 : 32'd0);
        chk("read_cycles", 32'(nr), (e || (w && sz == 2'd2)) ? 32'd0 : 32'd1);
        if (w && !e) begin
            chk("wr_addr", wa, a >> 2);
            chk("wr_data", wdat, nwv);
            ref_mem[a[9:2]] = nwv;
        end
        for (int i = 0; i < stall; i++) begin
            bus.req_valid = 1'b1;
            bus.req_write = 1'b0;
            bus.req_size  = 2'd2;
            bus.req_addr  = 32'h0;
            @(posedge clk); #1;
            chk("stall_valid", 32'(bus.resp_valid), 32'd1);
            chk("stall_rdata", bus.resp_rdata, er);
            chk("stall_err", 32'(bus.resp_err), 32'(e));
            chk("stall_ready", 32'(bus.req_ready), 32'd0);
            chk("stall_mem_idle", 32'(bus.mem_read | bus.mem_write), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("resp_drop", 32'(bus.resp_valid), 32'd0);
        chk("ready_after", 32'(bus.req_ready), 32'd1);
    endtask

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        total = 0;
        bad   = 0;
        bus.req_valid = 0; bus.req_write = 0; bus.req_size = 0; bus.req_signed = 0;
        bus.req_addr = 0; bus.req_wdata = 0; bus.resp_ready = 1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_mem_address", bus.mem_address, 32'd0);
        chk("rst_mem_wdata", bus.mem_write_data, 32'd0);
        chk("rst_mem_rw", 32'({bus.mem_read, bus.mem_write}), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        rst = 1'b1;

        for (int i = 0; i < 16; i++) do_op(1'b1, 2'd2, 1'b0, 32'(i * 4), $urandom, 0);
        do_op(1'b1, 2'd2, 1'b0, 32'h3FC, $urandom, 0);

        do_op(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 0);
        chk("mem4_word", mem[4], 32'hDEADBEEF);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 0);
        do_op(1'b1, 2'd2, 1'b0, 32'h04, 32'h11223344, 0);
        do_op(1'b1, 2'd0, 1'b0, 32'h06, 32'h000000AA, 0);
        chk("mem1_byte", mem[1], 32'h11AA3344);
        do_op(1'b0, 2'd0, 1'b1, 32'h06, 32'h0, 0);
        do_op(1'b0, 2'd0, 1'b0, 32'h06, 32'h0, 0);
        do_op(1'b0, 2'd1, 1'b1, 32'h06, 32'h0, 0);
        do_op(1'b1, 2'd1, 1'b0, 32'h04, 32'h0000BEEF, 0);
        chk("mem1_half", mem[1], 32'h11AABEEF);
        do_op(1'b0, 2'd1, 1'b1, 32'h04, 32'h0, 0);
        do_op(1'b0, 2'd2, 1'b0, 32'h02, 32'h0, 0);
        do_op(1'b1, 2'd1, 1'b0, 32'h01, 32'h1234, 0);
        do_op(1'b0, 2'd3, 1'b0, 32'h08, 32'h0, 0);
        do_op(1'b1, 2'd3, 1'b0, 32'h08, 32'h5555, 0);
        do_op(1'b0, 2'd2, 1'b0, 32'h400, 32'h0, 0);
        do_op(1'b1, 2'd0, 1'b0, 32'h400, 32'h77, 0);
        do_op(1'b0, 2'd2, 1'b0, 32'h3FC, 32'h0, 0);
        do_op(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5);
        do_op(1'b1, 2'd0, 1'b0, 32'h0B, 32'h5A, 3);

        for (int n = 0; n < 150; n++) begin
            a  = $urandom_range(0, 7) == 0 ? 32'd1024 + $urandom_range(0, 4095) :
                 $urandom_range(0, 9) == 0 ? 32'h3FC + $urandom_range(0, 3) : 32'(($urandom_range(0, 15) * 4) + $urandom_range(0, 3));
            sz = $urandom_range(0, 15) == 0 ? 2'd3 : 2'($urandom_range(0, 2));
            do_op(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(0, 7) == 0 ? 2 : 0);
        end

        bus.req_valid = 1'b1; bus.req_write = 1'b1; bus.req_size = 2'd0;
        bus.req_addr = 32'h06; bus.req_wdata = 32'h55;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        chk("midop_in_rmw", 32'(bus.mem_read), 32'd1);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("midop_mem_write", 32'(bus.mem_write), 32'd0);
        chk("midop_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("midop_req_ready", 32'(bus.req_ready), 32'd1);
        chk("midop_mem_address", bus.mem_address, 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midop_after_write", 32'(bus.mem_write), 32'd0);
        chk("midop_mem1", mem[1], ref_mem[1]);

        for (int i = 0; i < 16; i++) chk("final_mem", mem[i], ref_mem[i]);
        chk("final_mem_top", mem[255], ref_mem[255]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
